// File: rtl/spi_byte_rx_fifo.sv
// SPI mode-0 slave front end: MOSI bytes are deserialised into a FIFO for the
// control unit, and the control unit's status byte is shifted out on MISO.
module spi_byte_rx_fifo #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          spi_sck,
    input  logic                          spi_cs_n,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    input  logic [7:0]                    response_byte,
    output logic [7:0]                    out_byte,
    output logic                          out_valid,
    input  logic                          next,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_active
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   armed_q, armed_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_q, rx_d;
    logic [7:0]             tx_q, tx_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   ovf_q, ovf_d;
    logic [7:0]             mem_q [FIFO_DEPTH];

    logic sck_s, cs_s, mosi_s, synced, active;
    logic frame_start, frame_end, sck_rise, sck_fall;
    logic push, pop, full, wr_en;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    // fill marks when the chains hold real pin samples rather than reset values
    assign synced = fill_q[SYNC_STAGES-1];

    // A frame already in progress at reset release is ignored: receiving is
    // armed only once chip select has been seen inactive.
    assign armed_d      = armed_q | (synced & cs_s);
    assign sck_prev_d   = sck_s;
    assign cs_prev_d    = cs_s;
    assign frame_active = ~cs_s;
    assign active       = armed_q & ~cs_s;
    assign frame_start  = armed_q & cs_prev_q & ~cs_s;
    assign frame_end    = armed_q & ~cs_prev_q & cs_s;
    assign sck_rise     = active & ~sck_prev_q & sck_s;
    assign sck_fall     = active & sck_prev_q & ~sck_s;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        push      = 1'b0;
        if (frame_start) begin
            bit_cnt_d = 3'd0;
            tx_d      = response_byte;
        end else if (frame_end) begin
            bit_cnt_d = 3'd0;
        end else begin
            if (sck_rise) begin
                rx_d = {rx_q[6:0], mosi_s};
                if (bit_cnt_q == 3'd7) begin
                    push      = 1'b1;
                    bit_cnt_d = 3'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            if (sck_fall) begin
                // counter at 0 on a falling edge means a byte just completed
                if (bit_cnt_q == 3'd0) tx_d = response_byte;
                else                   tx_d = {tx_q[6:0], 1'b0};
            end
        end
    end

    assign spi_miso = frame_start ? response_byte[7] : (active & tx_q[7]);

    assign out_valid = (level_q != '0);
    assign full      = (level_q == LW'(FIFO_DEPTH));
    assign pop       = next & out_valid;
    assign wr_en     = push & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q | (push & full & ~pop);
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
        if (wr_en && !pop)      level_d = level_q + LW'(1);
        else if (pop && !wr_en) level_d = level_q - LW'(1);
    end

    assign out_byte   = out_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= rx_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            fill_q      <= fill_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_spi_byte_rx_fifo.sv
// Randomised bench for spi_byte_rx_fifo against a queue-based model of the
// FIFO contents, overflow flag and per-byte MISO response.
module tb_spi_byte_rx_fifo;

    localparam int DEPTH = 16;
    localparam int SYNC  = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          spi_sck = 1'b0;
    logic          spi_cs_n = 1'b1;
    logic          spi_mosi = 1'b0;
    logic          spi_miso;
    logic [7:0]    response_byte = 8'h00;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic          next = 1'b0;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic          frame_active;

    spi_byte_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset_n(reset_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .response_byte(response_byte),
        .out_byte(out_byte), .out_valid(out_valid), .next(next),
        .fifo_level(fifo_level), .overflow(overflow), .frame_active(frame_active)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] mq[$];
    bit         ovf_m = 1'b0;
    logic [7:0] resp_bound;
    bit         lat_chk = 1'b0;
    bit         chg_en = 1'b0;
    logic [7:0] chg_val = 8'h00;
    logic [7:0] miso_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".level"}, 32'(fifo_level), 32'(mq.size()));
        chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
        chk({tag, ".byte"}, 32'(out_byte), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
        chk({tag, ".ovf"}, 32'(overflow), 32'(ovf_m));
    endtask

    // Reference: a completed byte enters unless the queue is full; a pop in
    // the same cycle makes room first.
    task automatic model_push(input logic [7:0] b, input bit sp);
        if (sp && mq.size() > 0) void'(mq.pop_front());
        if (mq.size() < DEPTH) mq.push_back(b);
        else ovf_m = 1'b1;
    endtask

    task automatic xfer_byte(input logic [7:0] b, input int nbits, input bit sp,
                             output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            cyc(4);
            got[7-i] = spi_miso;
            spi_sck = 1'b1;
            if (i == 7 && sp) begin
                cyc(SYNC);
                next = 1'b1;
                cyc(1);
                next = 1'b0;
                cyc(4 - SYNC - 1);
            end else if (i == 7 && lat_chk) begin
                cyc(SYNC);
                chk("lat_early", 32'(out_valid), 32'h0);
                cyc(4 - SYNC);
                chk("lat_valid", 32'(out_valid), 32'h1);
            end else if (i == 3 && chg_en) begin
                response_byte = chg_val;
                chg_en = 1'b0;
                cyc(4);
            end else begin
                cyc(4);
            end
            spi_sck = 1'b0;
        end
    endtask

    task automatic frame(input int nbytes, input int abort_bits, input bit seq,
                         input logic [7:0] base, input bit sp_last);
        logic [7:0] b, got;
        spi_cs_n = 1'b0;
        resp_bound = response_byte;
        cyc(4);
        chk("frame_act", 32'(frame_active), 32'h1);
        for (int k = 0; k < nbytes; k++) begin
            b = seq ? 8'(base + 8'(k)) : 8'($urandom);
            xfer_byte(b, 8, sp_last && (k == nbytes - 1), got);
            chk("miso_byte", 32'(got), 32'(resp_bound));
            miso_log.push_back(got);
            model_push(b, sp_last && (k == nbytes - 1));
            resp_bound = response_byte;
        end
        if (abort_bits > 0) xfer_byte(8'($urandom), abort_bits, 1'b0, got);
        cyc(4);
        spi_cs_n = 1'b1;
        cyc(6);
        chk("miso_idle", 32'(spi_miso), 32'h0);
        chk("frame_idle", 32'(frame_active), 32'h0);
        check_state("frame");
    endtask

    task automatic pop_one(input string tag);
        check_state(tag);
        next = 1'b1;
        cyc(1);
        next = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        mq.delete();
        ovf_m = 1'b0;
        cyc(4);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        logic [7:0] got;
        cyc(3);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_byte", 32'(out_byte), 32'h0);
        chk("rst_miso", 32'(spi_miso), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_fa", 32'(frame_active), 32'h0);
        reset_n = 1'b1;
        cyc(4);

        // single byte with latency check
        response_byte = 8'h02;
        lat_chk = 1'b1;
        frame(1, 0, 1'b1, 8'hA5, 1'b0);
        lat_chk = 1'b0;
        chk("single_byte", 32'(out_byte), 32'hA5);
        chk("single_miso", 32'(miso_log[miso_log.size()-1]), 32'h02);
        pop_one("single_pop");
        check_state("single_empty");
        next = 1'b1;
        cyc(1);
        next = 1'b0;
        check_state("pop_empty");

        // burst past full
        frame(20, 0, 1'b1, 8'h00, 1'b0);
        chk("burst_level", 32'(fifo_level), 32'd16);
        chk("burst_ovf", 32'(overflow), 32'h1);
        for (int i = 0; i < 16; i++) begin
            chk("burst_order", 32'(out_byte), 32'(i));
            pop_one("burst_pop");
        end
        check_state("burst_empty");
        do_reset();

        // full with simultaneous pop on the 17th push
        frame(17, 0, 1'b1, 8'h40, 1'b1);
        chk("fullpop_level", 32'(fifo_level), 32'd16);
        chk("fullpop_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 15; i++) pop_one("fullpop_pop");
        chk("fullpop_last", 32'(out_byte), 32'h50);
        pop_one("fullpop_lastpop");

        // abort mid-byte, then clean byte
        frame(0, 5, 1'b0, 8'h00, 1'b0);
        frame(1, 0, 1'b1, 8'h3C, 1'b0);
        chk("abort_level", 32'(fifo_level), 32'h1);
        chk("abort_byte", 32'(out_byte), 32'h3C);
        pop_one("abort_pop");

        // MISO reload at byte boundary
        response_byte = 8'h01;
        chg_en = 1'b1;
        chg_val = 8'h04;
        frame(2, 0, 1'b0, 8'h00, 1'b0);
        chk("reload_b0", 32'(miso_log[miso_log.size()-2]), 32'h01);
        chk("reload_b1", 32'(miso_log[miso_log.size()-1]), 32'h04);
        pop_one("reload_pop0");
        pop_one("reload_pop1");

        // reset in the middle of a frame
        spi_cs_n = 1'b0;
        resp_bound = response_byte;
        cyc(4);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] b;
            b = 8'($urandom);
            xfer_byte(b, 8, 1'b0, got);
            model_push(b, 1'b0);
        end
        chk("mid_level", 32'(fifo_level), 32'd3);
        xfer_byte(8'($urandom), 4, 1'b0, got);
        reset_n = 1'b0;
        cyc(1);
        chk("mid_rst_level", 32'(fifo_level), 32'h0);
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_byte", 32'(out_byte), 32'h0);
        chk("mid_rst_miso", 32'(spi_miso), 32'h0);
        chk("mid_rst_ovf", 32'(overflow), 32'h0);
        chk("mid_rst_fa", 32'(frame_active), 32'h0);
        reset_n = 1'b1;
        mq.delete();
        ovf_m = 1'b0;
        xfer_byte(8'($urandom), 4, 1'b0, got);
        xfer_byte(8'($urandom), 8, 1'b0, got);
        cyc(4);
        chk("mid_ignored_level", 32'(fifo_level), 32'h0);
        chk("mid_ignored_valid", 32'(out_valid), 32'h0);
        spi_cs_n = 1'b1;
        cyc(6);
        frame(1, 0, 1'b0, 8'h00, 1'b0);
        pop_one("mid_pop");

        // randomised frames with random pops in between
        for (int f = 0; f < 30; f++) begin
            int nb, ab, np;
            response_byte = 8'($urandom);
            chg_en = ($urandom % 3 == 0);
            chg_val = 8'($urandom);
            nb = $urandom_range(0, 4);
            ab = ($urandom % 4 == 0) ? $urandom_range(1, 7) : 0;
            frame(nb, ab, 1'b0, 8'h00, 1'b0);
            np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) pop_one("rand_pop");
        end
        check_state("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
